// File: rtl/fb_pkg.sv
// Framebuffer geometry and pixel/address types shared by the drawing engine and the VGA driver.
package fb_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int AW        = 17;
  localparam int DW        = 12;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] fb_addr_t;
endpackage

// File: rtl/fb_rect_fill_if.sv
// Command handshake plus VRAM write port of the rectangle-fill engine.
interface fb_rect_fill_if;
  import fb_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  logic [8:0] cmd_x0;
  logic [7:0] cmd_y0;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;
  pixel_t   cmd_color;
  logic     busy;
  logic     done;
  fb_addr_t wr_addr;
  pixel_t   wr_data;
  logic     wr_en;

  // master issues commands and observes the write port; slave is the engine
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, wr_addr, wr_data, wr_en
  );
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: clips a command to the 320x240 framebuffer and writes one pixel per clock
// in row-major order, stepping addresses with adds only.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fb_rect_fill_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_DRAW, S_DONE} state_t;

  localparam logic [9:0]  FB_W10   = 10'(FB_W);
  localparam logic [9:0]  FB_H10   = 10'(FB_H);
  localparam fb_addr_t    ROW_STEP = fb_addr_t'(FB_W);

  state_t     state_reg, state_next;
  logic [8:0] x0_reg, x0_next, w_reg, w_next, x_reg, x_next;
  logic [7:0] y0_reg, y0_next, h_reg, h_next, y_reg, y_next;
  logic [9:0] x1_reg, x1_next, y1_reg, y1_next;
  pixel_t     color_reg, color_next, wr_data_reg, wr_data_next;
  fb_addr_t   row_base_reg, row_base_next, wr_addr_reg, wr_addr_next;
  logic       wr_en_reg, wr_en_next;

  logic [9:0] x_sum, y_sum, x_inc, y_inc;
  fb_addr_t   y0_ext, x0_ext, row_y0;
  logic       empty;

  always_comb begin
    x_sum  = {1'b0, x0_reg} + {1'b0, w_reg};
    y_sum  = {2'b0, y0_reg} + {2'b0, h_reg};
    x_inc  = {1'b0, x_reg} + 10'd1;
    y_inc  = {2'b0, y_reg} + 10'd1;
    y0_ext = fb_addr_t'(y0_reg);
    x0_ext = fb_addr_t'(x0_reg);
    // y*320 as y*256 + y*64
    row_y0 = (y0_ext << 8) + (y0_ext << 6);
    empty  = ({1'b0, x0_reg} >= FB_W10) || ({2'b0, y0_reg} >= FB_H10) ||
             (w_reg == 9'd0) || (h_reg == 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      x0_reg       <= '0;
      y0_reg       <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      x1_reg       <= '0;
      y1_reg       <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x0_reg       <= x0_next;
      y0_reg       <= y0_next;
      w_reg        <= w_next;
      h_reg        <= h_next;
      color_reg    <= color_next;
      x1_reg       <= x1_next;
      y1_reg       <= y1_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      row_base_reg <= row_base_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      wr_en_reg    <= wr_en_next;
    end
  end

  // The write registers always hold the pixel being emitted this cycle, so the first
  // pixel is loaded on the way out of CLIP and the last one is dropped entering DONE.
  always_comb begin
    state_next    = state_reg;
    x0_next       = x0_reg;
    y0_next       = y0_reg;
    w_next        = w_reg;
    h_next        = h_reg;
    color_next    = color_reg;
    x1_next       = x1_reg;
    y1_next       = y1_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    row_base_next = row_base_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    wr_en_next    = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          x0_next    = bus.cmd_x0;
          y0_next    = bus.cmd_y0;
          w_next     = bus.cmd_w;
          h_next     = bus.cmd_h;
          color_next = bus.cmd_color;
          state_next = S_CLIP;
        end
      end
      S_CLIP: begin
        x1_next = (x_sum > FB_W10) ? FB_W10 : x_sum;
        y1_next = (y_sum > FB_H10) ? FB_H10 : y_sum;
        if (empty) begin
          state_next = S_DONE;
        end else begin
          x_next        = x0_reg;
          y_next        = y0_reg;
          row_base_next = row_y0;
          wr_addr_next  = row_y0 + x0_ext;
          wr_data_next  = color_reg;
          wr_en_next    = 1'b1;
          state_next    = S_DRAW;
        end
      end
      S_DRAW: begin
        if (x_inc < x1_reg) begin
          x_next       = x_reg + 9'd1;
          wr_addr_next = wr_addr_reg + fb_addr_t'(1);
          wr_en_next   = 1'b1;
        end else if (y_inc < y1_reg) begin
          y_next        = y_reg + 8'd1;
          x_next        = x0_reg;
          row_base_next = row_base_reg + ROW_STEP;
          wr_addr_next  = row_base_reg + ROW_STEP + x0_ext;
          wr_en_next    = 1'b1;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.wr_en     = wr_en_reg;
endmodule
